// File: rtl/video_pkg.sv
// Shared pixel-stream types for the video pipeline: frame geometry,
// RGB444 pixel layout, stream beat format and source FSM states.
package video_pkg;

    localparam int unsigned IMG_WIDTH        = 320;
    localparam int unsigned IMG_HEIGHT       = 240;
    localparam int unsigned PIXELS_PER_FRAME = IMG_WIDTH * IMG_HEIGHT;

    typedef logic [11:0] pixel_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // One stream beat: pixel plus its packet framing flags.
    typedef struct packed {
        pixel_t data;
        logic   sop;
        logic   eop;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } stream_state_t;

    function automatic rgb444_t unpack_rgb(input pixel_t p);
        return rgb444_t'(p);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO of stream beats. Head beat is visible combinationally
// from storage; flush empties it in one cycle and overrides push/pop.
module stream_fifo2
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    input  logic       flush,
    output beat_t      head_beat,
    output logic [1:0] count
);

    beat_t      slot_q [2];
    beat_t      slot_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q,  count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        slot_d   = slot_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) begin
                slot_d[wr_ptr_q] = push_beat;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers, cleared to an empty FIFO on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    assign head_beat = slot_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/frame_stream_source.sv
// Frame stream source: reads a stored frame from a 1-cycle-latency pixel
// memory and emits it as a ready/valid packet stream with sop/eop framing.
module frame_stream_source #(
    parameter int unsigned IMG_WIDTH  = video_pkg::IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = video_pkg::IMG_HEIGHT,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              frame_done
);
    import video_pkg::*;

    localparam int unsigned       NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_PIXELS - 1);

    stream_state_t     state_q,      state_d;
    logic [ADDR_W-1:0] idx_q,        idx_d;
    logic              inflight_q,   inflight_d;
    logic              infl_sop_q,   infl_sop_d;
    logic              infl_eop_q,   infl_eop_d;
    logic              frame_done_q, frame_done_d;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_flush;
    beat_t      push_beat;
    beat_t      head_beat;
    logic [1:0] fifo_count;
    logic       eop_pop;
    logic       abort_prefetch;
    logic [2:0] level;
    logic       room;
    logic       issue;

    stream_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_beat (push_beat),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head_beat (head_beat),
        .count     (fifo_count)
    );

    // Read issue, FIFO control and next-state for FSM, index and in-flight tracking.
    // In continuous mode the next frame is prefetched straight after the last
    // read; if continuous turns out low when the eop beat leaves, those
    // prefetched beats (FIFO and in-flight) are discarded and the FSM idles.
    always_comb begin
        fifo_pop       = (fifo_count != 2'd0) && ready_in;
        eop_pop        = fifo_pop && head_beat.eop;
        abort_prefetch = eop_pop && !continuous;
        level          = {1'b0, fifo_count} + {2'b00, inflight_q};
        room           = fifo_pop ? (level < 3'd3) : (level < 3'd2);
        issue          = (state_q == ST_STREAM) && room && !abort_prefetch;
        fifo_push      = inflight_q && !abort_prefetch;
        fifo_flush     = abort_prefetch;
        push_beat      = '{data: pixel_t'(rd_data), sop: infl_sop_q, eop: infl_eop_q};

        state_d      = state_q;
        idx_d        = idx_q;
        inflight_d   = 1'b0;
        infl_sop_d   = infl_sop_q;
        infl_eop_d   = infl_eop_q;
        frame_done_d = eop_pop;

        if (issue) begin
            inflight_d = 1'b1;
            infl_sop_d = (idx_q == '0);
            infl_eop_d = (idx_q == LAST_IDX);
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                if (!continuous) begin
                    state_d = ST_DRAIN;
                end
            end else begin
                idx_d = idx_q + ADDR_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM, ST_DRAIN: begin
                if (eop_pop) begin
                    if (continuous) begin
                        state_d = ST_STREAM;
                    end else begin
                        state_d    = ST_IDLE;
                        idx_d      = '0;
                        inflight_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, read index and in-flight registers; reset drops any pending read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            inflight_q   <= 1'b0;
            infl_sop_q   <= 1'b0;
            infl_eop_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            inflight_q   <= inflight_d;
            infl_sop_q   <= infl_sop_d;
            infl_eop_q   <= infl_eop_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_en             = issue;
    assign rd_addr           = idx_q;
    assign valid_out         = (fifo_count != 2'd0);
    assign data_out          = valid_out ? DATA_W'(head_beat.data) : '0;
    assign startofpacket_out = valid_out && head_beat.sop;
    assign endofpacket_out   = valid_out && head_beat.eop;
    assign busy              = (state_q != ST_IDLE);
    assign frame_done        = frame_done_q;

endmodule

// File: doc/frame_stream_source.md
Name: frame_stream_source

Overview:
Streaming source end of the pixel interface. Reads a stored frame from a synchronous-read pixel memory and emits it as a ready/valid packet stream of RGB444 pixels, with startofpacket/endofpacket framing. It feeds the streaming filter chain, edge_filter among them, honours downstream backpressure, and issues one pixel per cycle when the sink is always ready.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
DATA_W, 12, pixel width (RGB444: [11:8] R, [7:4] G, [3:0] B)
ADDR_W, 17, memory address width; must satisfy 2**ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
clk  in  1  single system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a frame when idle
continuous  in  1  when high, the next frame starts automatically after the last pixel is accepted
rd_en  out  1  memory read strobe
rd_addr  out  ADDR_W  linear pixel index, row*IMG_WIDTH + col
rd_data  in  DATA_W  memory data, valid exactly 1 cycle after rd_en
ready_in  in  1  downstream ready (ready latency 0)
valid_out  out  1  data_out holds a pixel
startofpacket_out  out  1  first pixel of frame
endofpacket_out  out  1  last pixel of frame
data_out  out  DATA_W  pixel
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (async assert, sync release): every output is 0, FSM is IDLE, counters are 0, the output FIFO is empty, and in-flight read data is dropped.
- FSM states:
  - IDLE: go to STREAM on start.
  - STREAM: issue reads for indices 0..N-1, where N = IMG_WIDTH*IMG_HEIGHT.
  - DRAIN: all reads issued; wait until the last beat is accepted.
  - After the last beat is accepted: go to STREAM if continuous=1, otherwise go to IDLE.
- busy=1 in STREAM and DRAIN. start is ignored while busy.
- Transfer occurs on a cycle with valid_out && ready_in.
- While valid_out=1 and ready_in=0, data_out, startofpacket_out and endofpacket_out are held stable. valid_out never drops without a transfer.
- Output buffering: 2-entry FIFO. A read is issued only when (FIFO occupancy + reads in flight − pop this cycle) < 2. This guarantees no overflow and no dropped returns.
- Latency: start sampled at edge E0 → rd_en=1, rd_addr=0 in the cycle after E0. Data is captured at E2 and valid_out=1 after E2, i.e. 2 cycles from start to first valid.
- Throughput: with ready_in held at 1, one beat per cycle and no bubbles.
- Read index: increments by 1 per issued read and stops at N-1. In continuous mode it wraps to 0, and frame k+1 index 0 is issued the cycle after frame k index N-1 when FIFO space allows, with no inter-frame gap.
- startofpacket_out is asserted with pixel index 0; endofpacket_out with index N-1. Both flags are stored alongside the data in the FIFO.
- frame_done pulses the cycle after the eop transfer, once per frame, including in continuous mode.
- continuous is sampled at the eop transfer. Deasserting it mid-frame lets the current frame finish.
- ready_in low indefinitely: at most 2 reads beyond the last accepted pixel, then rd_en stays 0.
- Reset mid-frame: the stream aborts immediately with no eop emitted. The next start begins at index 0 with sop.

Decomposition:
- Package video_pkg: IMG_WIDTH, IMG_HEIGHT, PIXELS_PER_FRAME, pixel_t (logic [11:0]), rgb444_t struct (r,g,b 4-bit), beat_t struct {pixel_t data; sop; eop}.
- Sub-module stream_fifo2: a 2-entry FIFO of beat_t with push/pop/count, reset to empty. Same clk/reset.
- The top holds the FSM, index counter and in-flight tracking.

Test Plan:
1. Reset asserted at any time → all outputs 0 within the same cycle (async); after release with no start, valid_out/rd_en stay 0 for 50 cycles.
2. IMG_WIDTH=4, IMG_HEIGHT=2, memory returns rd_data=addr, ready_in=1, start pulse → valid_out on 8 consecutive cycles with data 0..7 starting 2 cycles after start; sop only on 0, eop only on 7; frame_done pulses 1 cycle after the beat-7 transfer; busy falls.
3. Same config, ready_in toggling 1,0,1,0 → every pixel 0..7 is delivered once, in order; data is held stable while ready_in=0; rd_addr is never more than 2 ahead of the accepted count.
4. ready_in=0 for 20 cycles after pixel 3 is accepted → valid_out stays 1 with data_out=4 held; exactly 2 reads are outstanding/buffered; rd_en=0 for the remainder of the stall; the stream resumes 4,5,6,7.
5. continuous=1, ready_in=1 → beat 7 (eop) is followed next cycle by beat 0 (sop) of the next frame; frame_done pulses per frame; a start pulse mid-frame has no effect.
6. Reset asserted after pixel 5 → outputs 0; after release, a start yields data 0 with sop and a full 8-beat frame.
